ifetch: RTL
===========

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSN, default 32'h0000_0000, the bubble word placed in the IF/ID register.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port stall  input  1  hazard hold; freezes PC and the IF/ID register.
REQ-006 SHALL have port redirect  input  1  taken branch or jump resolved downstream; squashes fetch.
REQ-007 SHALL have port redirect_pc  input  32  target PC, valid when redirect=1.
REQ-008 SHALL have port halt  input  1  trap decoded in ID (inverse of the ID not_trap output).
REQ-009 SHALL have port imem_data  input  32  instruction word for imem_addr, combinational same-cycle read.
REQ-010 SHALL have port imem_addr  output  32  current PC presented to instruction memory.
REQ-011 SHALL have port instruction  output  32  IF/ID instruction, fed directly to the ID stage.
REQ-012 SHALL have port pc_id  output  32  PC of the instruction held in IF/ID.
REQ-013 SHALL have port pc4_id  output  32  pc_id+4, used by the link and branch-target logic.
REQ-014 SHALL have port valid_id  output  1  1 when IF/ID holds a real fetched instruction, 0 for a bubble.
REQ-015 SHALL have port halted  output  1  1 while in state HALT.
REQ-016 SHALL have port fetch_count  output  32  number of instructions accepted into IF/ID since reset.

Function
REQ-017 SHALL drive imem_addr from the PC register combinationally.
REQ-018 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 SHALL implement two states: RUN and HALT.
REQ-020 SHALL apply per-edge priority: redirect > halt > stall > normal advance.
REQ-021 Normal advance (RUN, no stall/halt/redirect): PC<=PC+4; instruction<=imem_data; pc_id<=PC; pc4_id<=PC+4; valid_id<=1; fetch_count+=1.
REQ-022 Stall (RUN, no halt/redirect): PC, IF/ID contents, valid_id and fetch_count hold.
REQ-023 Redirect (any state): PC<=redirect_pc; instruction<=NOP_INSN; valid_id<=0; pc_id/pc4_id hold; fetch_count holds; state<=RUN.
REQ-024 Redirect asserted together with stall: redirect wins; the stall is ignored that edge.
REQ-025 Halt in RUN without redirect: PC holds; instruction<=NOP_INSN; valid_id<=0; state<=HALT.
REQ-026 In HALT without redirect: PC, IF/ID contents and fetch_count hold; stall and halt have no effect.
REQ-027 HALT SHALL be left only by redirect (squashed wrong-path trap) or by reset.
REQ-028 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 Fetch latency SHALL be one cycle: the word at imem_addr in cycle n appears on instruction in cycle n+1.
REQ-030 The first taken edge after reset SHALL fetch from RESET_PC.
REQ-031 redirect_pc SHALL NOT be alignment-checked; its low bits pass through unmodified.

Reset
REQ-032 rst_n=0 SHALL immediately force: PC=RESET_PC, instruction=NOP_INSN, pc_id=0, pc4_id=0, valid_id=0, fetch_count=0, state=RUN, halted=0.
REQ-033 Reset SHALL override all inputs, including an in-flight redirect or a HALT state.
REQ-034 Release of rst_n SHALL take effect at the next rising clk edge, with no extra bubble cycle.

Verification
REQ-035 Reset release, imem returns 32'hA000_0001 at 0x0 and 32'hA000_0002 at 0x4, no stall -> cycle 1: instruction=A000_0001, pc_id=0, pc4_id=4, valid_id=1; cycle 2: instruction=A000_0002, pc_id=4; fetch_count=2.
REQ-036 Stall high for 3 cycles with PC=0x8 -> imem_addr stays 0x8 and IF/ID is unchanged for 3 cycles; after release, pc_id=0x8.
REQ-037 redirect=1, redirect_pc=0x100, with stall=1 in the same cycle -> next cycle: imem_addr=0x100, instruction=NOP_INSN, valid_id=0; following cycle: pc_id=0x100, valid_id=1.
REQ-038 halt=1 at PC=0x20 -> halted=1, valid_id=0, imem_addr stays 0x20 for 5 idle cycles; then redirect to 0x40 -> halted=0 and fetch resumes at 0x40.
REQ-039 Redirect to 0xFFFF_FFFC, then advance -> pc4_id=0, imem_addr=0x0.
REQ-040 Assert rst_n=0 mid-cycle while in HALT with fetch_count=7 -> outputs reset asynchronously before the next edge: fetch_count=0, halted=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage with PC register, IF/ID register and RUN/HALT control.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   stall                - hold PC and IF/ID
//   redirect/redirect_pc - squash fetch and restart at redirect_pc
//   halt                 - trap seen in ID; park the stage until redirect or reset
//   imem_addr/imem_data  - combinational instruction memory port
//   instruction, pc_id, pc4_id, valid_id - IF/ID register contents
//   halted, fetch_count  - status
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] instruction,
    output logic [31:0] pc_id,
    output logic [31:0] pc4_id,
    output logic        valid_id,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        do_redirect;
    logic        do_bubble;
    logic        do_advance;

    // Natural 32-bit overflow gives the required wrap at 0xFFFF_FFFC.
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: redirect always returns to RUN, even out of HALT.
    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = RUN;
        end else if (state == RUN && halt) begin
            state_nxt = HALT;
        end
    end

    // Output / action decode with priority redirect > halt > stall > advance.
    // In HALT only a redirect does anything.
    always_comb begin
        do_redirect = redirect;
        do_bubble   = 1'b0;
        do_advance  = 1'b0;
        if (!redirect && state == RUN) begin
            do_bubble  = halt;
            do_advance = !halt && !stall;
        end
        halted = (state == HALT);
    end

    // PC and IF/ID datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instruction <= NOP_INSN;
            pc_id       <= 32'd0;
            pc4_id      <= 32'd0;
            valid_id    <= 1'b0;
            fetch_count <= 32'd0;
        end else if (do_redirect) begin
            // pc_id/pc4_id keep the last real fetch; the bubble is marked by valid_id.
            pc          <= redirect_pc;
            instruction <= NOP_INSN;
            valid_id    <= 1'b0;
        end else if (do_bubble) begin
            instruction <= NOP_INSN;
            valid_id    <= 1'b0;
        end else if (do_advance) begin
            pc          <= pc_plus4;
            instruction <= imem_data;
            pc_id       <= pc;
            pc4_id      <= pc_plus4;
            valid_id    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule
